para_hit_mc: RTL and testbench
==============================

Name: para_hit_mc

Overview:
- Multi-channel, parametrised successor to the single-channel hit/parameter extractor.
- Accepts a time-multiplexed sample stream tagged with a channel index.
- Runs an independent threshold/hold/lock FSM per channel, tracks the peak sample of each hit, and pushes hit events into a buffered output FIFO with valid/ready handshake.
- Configuration and status are accessed over the 8-bit fx register bus, selected by dev_id.

Parameters:
N_CH, 8, number of channels; power of 2, >=2
CH_W, $clog2(N_CH), channel index width
DATA_W, 16, sample width, unsigned
CNT_W, 16, hold/lock counter width
FIFO_DEPTH, 16, event FIFO depth; power of 2, >=4

Ports:
clk_sys  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
sm_data  in  DATA_W  sample value, unsigned
sm_ch  in  CH_W  channel of sm_data
sm_vld  in  1  sample strobe; one sample per cycle max
ph_data  out  CH_W+DATA_W+16  event word {ch, peak, hit_id}
ph_vld  out  1  event available; first-word fall-through
ph_rdy  in  1  consumer accepts when ph_vld&&ph_rdy
fx_wr  in  1  register write strobe
fx_waddr  in  22  write address
fx_data  in  8  write data
fx_rd  in  1  register read strobe
fx_raddr  in  22  read address
fx_q  out  8  read data
dev_id  in  6  block select; matched against addr[21:16]

Behaviour:
- Reset: all outputs 0. FIFO empty. All channels IDLE. hit_id=0. Registers take their reset values.
- Register decode: access only when addr[21:16]==dev_id; offset is addr[7:0].
- Register map (reset value in brackets):
  - 0x00/01 cfg_th lo/hi [0x0800]
  - 0x02/03 cfg_hdt lo/hi [4]
  - 0x04/05 cfg_ldt lo/hi [16]
  - 0x06 ctrl: bit0 enable [1]; bit1 clr, write-1 self-clearing
  - 0x08/09 stu_hit_cnt (RO, 16b, wraps)
  - 0x0A stu_ovf (RO, saturates at 255)
  - 0x0B fifo level (RO)
- Reads: fx_q is registered and valid the cycle after fx_rd; it holds its value otherwise. An unselected or unmapped read returns 0x00.
- Per-channel FSM: states IDLE, ARM, LOCK. Each channel stores state, cnt (CNT_W) and peak (DATA_W). Only samples whose sm_ch matches advance that channel.
  - IDLE: sample>=cfg_th -> cnt=1, peak=sample, go ARM. If cfg_hdt<=1, fire instead and go LOCK.
  - ARM: sample>=cfg_th -> cnt++, peak=max(peak,sample). When the new cnt==cfg_hdt, fire and go LOCK with cnt=0. Sample<cfg_th -> go IDLE, no event.
  - LOCK: every sample counts regardless of level. When cnt reaches cfg_ldt, go IDLE. cfg_ldt=0 -> IDLE on the next sample.
  - cnt saturates at its maximum and never wraps.
- Fire: pushes {ch, peak including the current sample, hit_id}. On push, hit_id and stu_hit_cnt increment.
- Pipeline: 2 stages (state read, update/write-back).
  - Back-to-back samples on the same channel require forwarding of the write-back state; no stall, no lost samples.
  - With the FIFO empty, ph_vld rises 2 cycles after the firing sm_vld cycle.
- FIFO full:
  - An event is dropped and stu_ovf increments; hit_id is not incremented.
  - Exception: a pop in the same cycle (ph_vld&&ph_rdy) lets the push be accepted.
- ph_data/ph_vld remain stable while ph_vld&&!ph_rdy.
- enable=0: all channels forced to IDLE; samples ignored; FIFO still drains.
- clr: zeros hit_id, stu_hit_cnt and stu_ovf, and empties the FIFO, all in the same cycle. If a fire coincides with clr, the clr wins.
- Config changes apply to the next sample; in-flight counts are not reset.

Optional Feature:
- Macro: PARA_TIMESTAMP_EN.
- Defined: adds a 32-bit free-running cycle counter (reset 0, wraps). ph_data becomes {ts, ch, peak, hit_id}, where ts is the cycle of the firing sm_vld.
- Undefined: no counter; ph_data is CH_W+DATA_W+16 bits.

Decomposition:
- para_pkg: register offsets, FSM state encoding, register reset values, ph_data field positions.
- Sub-module para_evt_fifo: parametrised sync FIFO (DEPTH, WIDTH) with FWFT, push/pop, full/empty and level outputs.

Test Plan:
- Defaults, ch3 fed 4 samples of 0x0900 -> exactly one event {3, 0x0900, 0}. ph_vld high 2 cycles after the 4th sample. Following 16 ch3 samples are ignored.
- ch1 samples 0x0900, 0x0A00, 0x0700 -> back to IDLE, no event. Then 4×0x0C00 -> event with peak 0x0C00.
- ch0/ch5 interleaved every cycle, each 4 above threshold -> two events, correct channels, hit_id 0 then 1. Also run same-channel back-to-back samples to exercise forwarding.
- ph_rdy=0, 20 hits on distinct windows -> 16 stored, stu_ovf=4, then drain in order. Full with simultaneous pop+push -> push accepted.
- cfg_hdt=1, cfg_ldt=0 over fx; single 0x0FFF -> event at once, and the next sample re-arms. Read 0x0B returns level on fx_q one cycle after fx_rd. Read with wrong dev_id -> 0x00.
- Write ctrl=0x02 mid-hit with FIFO non-empty -> FIFO empty, counters 0. Assert rst_n low mid-ARM -> all outputs 0 immediately.

Source files
------------

// File: rtl/para_pkg.sv
// Shared definitions for the multi-channel hit extractor: register map,
// channel FSM encoding, register reset values and event word layout.
// Optional feature macro: PARA_TIMESTAMP_EN (adds a 32-bit cycle stamp to events).
package para_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_LOCK = 2'd2
  } ch_state_e;

  // register offsets (addr[7:0])
  localparam logic [7:0] REG_TH_LO   = 8'h00;
  localparam logic [7:0] REG_TH_HI   = 8'h01;
  localparam logic [7:0] REG_HDT_LO  = 8'h02;
  localparam logic [7:0] REG_HDT_HI  = 8'h03;
  localparam logic [7:0] REG_LDT_LO  = 8'h04;
  localparam logic [7:0] REG_LDT_HI  = 8'h05;
  localparam logic [7:0] REG_CTRL    = 8'h06;
  localparam logic [7:0] REG_HCNT_LO = 8'h08;
  localparam logic [7:0] REG_HCNT_HI = 8'h09;
  localparam logic [7:0] REG_OVF     = 8'h0A;
  localparam logic [7:0] REG_LEVEL   = 8'h0B;

  // register reset values
  localparam logic [15:0] TH_RST  = 16'h0800;
  localparam logic [15:0] HDT_RST = 16'd4;
  localparam logic [15:0] LDT_RST = 16'd16;
  localparam logic        EN_RST  = 1'b1;

  // event word layout, LSB first: hit_id, peak, ch, [ts]
  localparam int HID_W   = 16;
  localparam int HID_LSB = 0;
  localparam int PEAK_LSB = HID_W;
`ifdef PARA_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif

  function automatic int ch_lsb(input int data_w);
    return HID_W + data_w;
  endfunction

  function automatic int ts_lsb(input int ch_w, input int data_w);
    return HID_W + data_w + ch_w;
  endfunction

endpackage

// File: rtl/para_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for hit events. A push while full
// is accepted only when a pop happens in the same cycle. Output reads 0 when empty.
module para_evt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 35
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign level_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // storage; contents are don't-care until written, output is masked when empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // read/write pointers with an extra wrap bit so full and empty differ
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/para_hit_mc.sv
// Multi-channel hit extractor. One time-multiplexed sample per cycle runs
// through a 2-stage pipeline (state read, update/write-back) against a
// per-channel IDLE/ARM/LOCK FSM; fired hits go into an event FIFO.
// Optional feature macro: PARA_TIMESTAMP_EN.
module para_hit_mc
  import para_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int CH_W       = $clog2(N_CH),
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk_sys,
  input  logic                             rst_n,
  input  logic [DATA_W-1:0]                sm_data,
  input  logic [CH_W-1:0]                  sm_ch,
  input  logic                             sm_vld,
  output logic [TS_W+CH_W+DATA_W+HID_W-1:0] ph_data,
  output logic                             ph_vld,
  input  logic                             ph_rdy,
  input  logic                             fx_wr,
  input  logic [21:0]                      fx_waddr,
  input  logic [7:0]                       fx_data,
  input  logic                             fx_rd,
  input  logic [21:0]                      fx_raddr,
  output logic [7:0]                       fx_q,
  input  logic [5:0]                       dev_id
);

  localparam int EVT_W  = TS_W + CH_W + DATA_W + HID_W;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CH_LSB = ch_lsb(DATA_W);

  typedef struct packed {
    ch_state_e         st;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] peak;
  } ch_t;

  localparam ch_t CH_RST = '{st: ST_IDLE, cnt: '0, peak: '0};

  // configuration / status
  logic [15:0]      th_q, hdt_q, ldt_q;
  logic             en_q;
  logic [HID_W-1:0] hid_q;
  logic [15:0]      hcnt_q;
  logic [7:0]       ovf_q, fxq_q, fxq_d;

  // pipeline
  ch_t               ch_q [N_CH];
  logic              s1_vld_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic [DATA_W-1:0] s1_data_q;
  ch_t               s1_st_q;
  ch_t               nxt;
  logic              fire, wb_en, above;
  logic [DATA_W-1:0] pk_max, th_c;
  logic [CNT_W-1:0]  cnt_inc, hdt_c, ldt_c;

  // bus / fifo glue
  logic             wsel, clr;
  logic             push_req, push_ok, drop, pop;
  logic             f_full, f_empty;
  logic [LVL_W-1:0] f_lvl;
  logic [EVT_W-1:0] evt;
  logic             unused_addr;

  assign wsel  = fx_wr && (fx_waddr[21:16] == dev_id);
  assign clr   = wsel && (fx_waddr[7:0] == REG_CTRL) && fx_data[1];
  assign wb_en = s1_vld_q && en_q;
  assign th_c  = DATA_W'(th_q);
  assign hdt_c = CNT_W'(hdt_q);
  assign ldt_c = CNT_W'(ldt_q);
  assign unused_addr = ^{fx_waddr[15:8], fx_raddr[15:8]};

`ifdef PARA_TIMESTAMP_EN
  logic [31:0] ts_q, s1_ts_q;

  // free-running cycle stamp, captured alongside each sample
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      s1_ts_q <= '0;
    end else begin
      ts_q    <= ts_q + 32'd1;
      s1_ts_q <= ts_q;
    end
  end
`endif

  // stage 1: capture sample and its channel state, bypassing the write-back in flight
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_data_q <= '0;
      s1_st_q   <= CH_RST;
    end else begin
      s1_vld_q  <= sm_vld && en_q;
      s1_ch_q   <= sm_ch;
      s1_data_q <= sm_data;
      s1_st_q   <= (wb_en && (s1_ch_q == sm_ch)) ? nxt : ch_q[sm_ch];
    end
  end

  // stage 2: channel FSM next state and fire decision
  always_comb begin
    nxt     = s1_st_q;
    fire    = 1'b0;
    above   = (s1_data_q >= th_c);
    pk_max  = (s1_data_q > s1_st_q.peak) ? s1_data_q : s1_st_q.peak;
    cnt_inc = (&s1_st_q.cnt) ? s1_st_q.cnt : s1_st_q.cnt + 1'b1;
    case (s1_st_q.st)
      ST_IDLE: begin
        if (above) begin
          nxt.peak = s1_data_q;
          if (hdt_c <= CNT_W'(1)) begin
            fire    = 1'b1;
            nxt.st  = ST_LOCK;
            nxt.cnt = '0;
          end else begin
            nxt.st  = ST_ARM;
            nxt.cnt = CNT_W'(1);
          end
        end
      end
      ST_ARM: begin
        if (above) begin
          nxt.peak = pk_max;
          // >= so a hold time lowered mid-hit still fires instead of stalling in ARM
          if (cnt_inc >= hdt_c) begin
            fire    = 1'b1;
            nxt.st  = ST_LOCK;
            nxt.cnt = '0;
          end else begin
            nxt.cnt = cnt_inc;
          end
        end else begin
          nxt.st  = ST_IDLE;
          nxt.cnt = '0;
        end
      end
      ST_LOCK: begin
        nxt.cnt = cnt_inc;
        if (cnt_inc >= ldt_c) begin
          nxt.st  = ST_IDLE;
          nxt.cnt = '0;
        end
      end
      default: nxt = CH_RST;
    endcase
  end

  // event word assembly for the firing sample
  always_comb begin
    evt = '0;
    evt[HID_LSB +: HID_W]   = hid_q;
    evt[PEAK_LSB +: DATA_W] = nxt.peak;
    evt[CH_LSB +: CH_W]     = s1_ch_q;
`ifdef PARA_TIMESTAMP_EN
    evt[ts_lsb(CH_W, DATA_W) +: TS_W] = s1_ts_q;
`endif
  end

  // per-channel state write-back; disable parks every channel in IDLE
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) ch_q[i] <= CH_RST;
    end else if (!en_q) begin
      for (int i = 0; i < N_CH; i++) ch_q[i] <= CH_RST;
    end else if (wb_en) begin
      ch_q[s1_ch_q] <= nxt;
    end
  end

  assign pop      = !f_empty && ph_rdy;
  assign push_req = wb_en && fire && !clr;
  assign push_ok  = push_req && (!f_full || pop);
  assign drop     = push_req && f_full && !pop;
  assign ph_vld   = !f_empty;

  para_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (rst_n),
    .clr_i   (clr),
    .push_i  (push_req),
    .data_i  (evt),
    .pop_i   (pop),
    .data_o  (ph_data),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_lvl)
  );

  // register read mux; unselected or unmapped offsets read as zero
  always_comb begin
    fxq_d = 8'h00;
    if (fx_raddr[21:16] == dev_id) begin
      case (fx_raddr[7:0])
        REG_TH_LO:   fxq_d = th_q[7:0];
        REG_TH_HI:   fxq_d = th_q[15:8];
        REG_HDT_LO:  fxq_d = hdt_q[7:0];
        REG_HDT_HI:  fxq_d = hdt_q[15:8];
        REG_LDT_LO:  fxq_d = ldt_q[7:0];
        REG_LDT_HI:  fxq_d = ldt_q[15:8];
        REG_CTRL:    fxq_d = {7'd0, en_q};
        REG_HCNT_LO: fxq_d = hcnt_q[7:0];
        REG_HCNT_HI: fxq_d = hcnt_q[15:8];
        REG_OVF:     fxq_d = ovf_q;
        REG_LEVEL:   fxq_d = 8'(f_lvl);
        default:     fxq_d = 8'h00;
      endcase
    end
  end

  assign fx_q = fxq_q;

  // config writes, read data register, hit/overflow counters; clr beats a coincident fire
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      th_q   <= TH_RST;
      hdt_q  <= HDT_RST;
      ldt_q  <= LDT_RST;
      en_q   <= EN_RST;
      hid_q  <= '0;
      hcnt_q <= '0;
      ovf_q  <= '0;
      fxq_q  <= '0;
    end else begin
      if (wsel) begin
        case (fx_waddr[7:0])
          REG_TH_LO:  th_q[7:0]   <= fx_data;
          REG_TH_HI:  th_q[15:8]  <= fx_data;
          REG_HDT_LO: hdt_q[7:0]  <= fx_data;
          REG_HDT_HI: hdt_q[15:8] <= fx_data;
          REG_LDT_LO: ldt_q[7:0]  <= fx_data;
          REG_LDT_HI: ldt_q[15:8] <= fx_data;
          REG_CTRL:   en_q        <= fx_data[0];
          default: ;
        endcase
      end
      if (fx_rd) fxq_q <= fxq_d;
      if (clr) begin
        hid_q  <= '0;
        hcnt_q <= '0;
        ovf_q  <= '0;
      end else begin
        if (push_ok) begin
          hid_q  <= hid_q + 1'b1;
          hcnt_q <= hcnt_q + 1'b1;
        end
        if (drop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_para_hit_mc.sv
// Directed bench for para_hit_mc: latency, hold/lock counts, forwarding,
// interleaved channels, FIFO overflow, clr, register bus and async reset.
`timescale 1ns/1ps
module tb_para_hit_mc;

  localparam int CH_W   = 3;
  localparam int DATA_W = 16;
`ifdef PARA_TIMESTAMP_EN
  localparam int PH_W = 32 + CH_W + DATA_W + 16;
`else
  localparam int PH_W = CH_W + DATA_W + 16;
`endif
  localparam logic [5:0] DEV = 6'h15;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b0;
  logic [DATA_W-1:0] sm_data = '0;
  logic [CH_W-1:0]   sm_ch   = '0;
  logic              sm_vld  = 1'b0;
  logic [PH_W-1:0]   ph_data;
  logic              ph_vld;
  logic              ph_rdy  = 1'b0;
  logic              fx_wr   = 1'b0;
  logic [21:0]       fx_waddr = '0;
  logic [7:0]        fx_data = '0;
  logic              fx_rd   = 1'b0;
  logic [21:0]       fx_raddr = '0;
  logic [7:0]        fx_q;
  logic [5:0]        dev_id  = DEV;
  logic [63:0]       phw;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  assign phw = 64'(ph_data[CH_W+DATA_W+15:0]);

  para_hit_mc u_dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .sm_data  (sm_data),
    .sm_ch    (sm_ch),
    .sm_vld   (sm_vld),
    .ph_data  (ph_data),
    .ph_vld   (ph_vld),
    .ph_rdy   (ph_rdy),
    .fx_wr    (fx_wr),
    .fx_waddr (fx_waddr),
    .fx_data  (fx_data),
    .fx_rd    (fx_rd),
    .fx_raddr (fx_raddr),
    .fx_q     (fx_q),
    .dev_id   (dev_id)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ev(input logic [2:0] ch, input logic [15:0] pk, input logic [15:0] id);
    return {29'd0, ch, pk, id};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic smp(input int ch, input logic [15:0] d);
    sm_vld  = 1'b1;
    sm_ch   = ch[2:0];
    sm_data = d;
    @(negedge clk_sys);
    sm_vld  = 1'b0;
    sm_data = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    fx_wr    = 1'b1;
    fx_waddr = {DEV, 8'h00, off};
    fx_data  = d;
    @(negedge clk_sys);
    fx_wr    = 1'b0;
  endtask

  task automatic rd(input logic [5:0] dv, input logic [7:0] off, output logic [7:0] q);
    fx_rd    = 1'b1;
    fx_raddr = {dv, 8'h00, off};
    @(negedge clk_sys);
    fx_rd    = 1'b0;
    q        = fx_q;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] off, input logic [7:0] exp);
    logic [7:0] q;
    rd(DEV, off, q);
    chk(tag, 64'(q), 64'(exp));
  endtask

  task automatic pop(input string tag, input logic [63:0] exp);
    int n = 0;
    while (!ph_vld && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    chk({tag, "_vld"}, 64'(ph_vld), 64'd1);
    chk(tag, phw, exp);
    ph_rdy = 1'b1;
    @(negedge clk_sys);
    ph_rdy = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q;

    // reset state
    idle(3);
    chk("rst_vld",  64'(ph_vld), 0);
    chk("rst_data", phw, 0);
    chk("rst_fxq",  64'(fx_q), 0);
    rst_n = 1'b1;
    idle(1);
    chk_rd("rst_th_lo", 8'h00, 8'h00);
    chk_rd("rst_th_hi", 8'h01, 8'h08);
    chk_rd("rst_hdt",   8'h02, 8'h04);
    chk_rd("rst_ldt",   8'h04, 8'h10);
    chk_rd("rst_ctrl",  8'h06, 8'h01);
    chk_rd("rst_lvl",   8'h0B, 8'h00);

    // A: 4 back-to-back samples on ch3, 2-cycle latency, 16-sample lock
    repeat (4) smp(3, 16'h0900);
    chk("a_lat1", 64'(ph_vld), 0);
    idle(1);
    chk("a_lat2", 64'(ph_vld), 1);
    pop("a_evt", ev(3, 16'h0900, 16'd0));
    repeat (16) smp(3, 16'h0900);
    idle(3);
    chk("a_lock_quiet", 64'(ph_vld), 0);
    chk_rd("a_hcnt", 8'h08, 8'd1);
    repeat (4) smp(3, 16'h0900);
    pop("a_rearm", ev(3, 16'h0900, 16'd1));

    // B: dropout before hold completes, then a clean hit
    smp(1, 16'h0900); smp(1, 16'h0A00); smp(1, 16'h0700);
    idle(3);
    chk("b_no_evt", 64'(ph_vld), 0);
    repeat (4) smp(1, 16'h0C00);
    pop("b_evt", ev(1, 16'h0C00, 16'd2));

    // C: clr, then ch0/ch5 interleaved every cycle
    wr(8'h06, 8'h03);
    chk_rd("c_hcnt_clr", 8'h08, 8'd0);
    smp(0, 16'h0900); smp(5, 16'h0850);
    smp(0, 16'h0B00); smp(5, 16'h0900);
    smp(0, 16'h0A00); smp(5, 16'h0850);
    smp(0, 16'h0900); smp(5, 16'h0F00);
    pop("c_evt0", ev(0, 16'h0B00, 16'd0));
    pop("c_evt1", ev(5, 16'h0F00, 16'd1));
    chk_rd("c_hcnt", 8'h08, 8'd2);

    // D: hold=1, lock=0
    wr(8'h02, 8'h01); wr(8'h03, 8'h00); wr(8'h04, 8'h00); wr(8'h05, 8'h00);
    smp(6, 16'h0FFF);
    chk("d_lat1", 64'(ph_vld), 0);
    idle(1);
    chk("d_now", 64'(ph_vld), 1);
    chk_rd("d_lvl", 8'h0B, 8'd1);
    pop("d_evt", ev(6, 16'h0FFF, 16'd2));
    smp(6, 16'h0FFF);
    idle(3);
    chk("d_lock_one", 64'(ph_vld), 0);
    smp(6, 16'h0FFF);
    pop("d_rearm", ev(6, 16'h0FFF, 16'd3));
    smp(7, 16'h07FF);
    idle(3);
    chk("d_below_th", 64'(ph_vld), 0);
    smp(7, 16'h0800);
    pop("d_at_th", ev(7, 16'h0800, 16'd4));

    // E: 20 hits into a 16-deep FIFO with no consumer
    wr(8'h06, 8'h03);
    for (int k = 0; k < 20; k++) begin
      smp(2, 16'(16'h1000 + k));
      smp(2, 16'h0000);
    end
    idle(3);
    chk_rd("e_lvl",  8'h0B, 8'd16);
    chk_rd("e_ovf",  8'h0A, 8'd4);
    chk_rd("e_hcnt", 8'h08, 8'd16);
    chk("e_hold", phw, ev(2, 16'h1000, 16'd0));
    idle(2);
    chk("e_hold2", phw, ev(2, 16'h1000, 16'd0));
    smp(2, 16'h2000);
    ph_rdy = 1'b1;
    @(negedge clk_sys);
    ph_rdy = 1'b0;
    smp(2, 16'h0000);
    idle(3);
    chk_rd("e_lvl_pp",  8'h0B, 8'd16);
    chk_rd("e_ovf_pp",  8'h0A, 8'd4);
    chk_rd("e_hcnt_pp", 8'h08, 8'd17);
    for (int k = 1; k < 16; k++) pop("e_drain", ev(2, 16'(16'h1000 + k), 16'(k)));
    pop("e_last", ev(2, 16'h2000, 16'd16));
    chk_rd("e_empty", 8'h0B, 8'd0);

    // F: clr mid-hit with FIFO non-empty
    smp(4, 16'h0900);
    wr(8'h02, 8'h04);
    smp(4, 16'h0000);
    wr(8'h04, 8'h10);
    smp(4, 16'h0900); smp(4, 16'h0900);
    idle(1);
    chk("f_pre", 64'(ph_vld), 1);
    wr(8'h06, 8'h02);
    chk("f_vld", 64'(ph_vld), 0);
    chk_rd("f_lvl",  8'h0B, 8'd0);
    chk_rd("f_hcnt", 8'h08, 8'd0);
    chk_rd("f_ovf",  8'h0A, 8'd0);
    chk_rd("f_ctrl", 8'h06, 8'd0);
    wr(8'h06, 8'h01);
    smp(4, 16'h0900); smp(4, 16'h0900);
    idle(3);
    chk("f_forced_idle", 64'(ph_vld), 0);
    smp(4, 16'h0900); smp(4, 16'h0900);
    pop("f_evt", ev(4, 16'h0900, 16'd0));

    // G: read select and hold behaviour
    chk_rd("g_ctrl", 8'h06, 8'h01);
    idle(2);
    chk("g_hold", 64'(fx_q), 1);
    rd(DEV ^ 6'h01, 8'h06, q);
    chk("g_wrong_dev", 64'(q), 0);
    chk_rd("g_ctrl2", 8'h06, 8'h01);
    rd(DEV, 8'h07, q);
    chk("g_unmapped", 64'(q), 0);

    // H: async reset while ch3 is in ARM and the FIFO holds an event
    repeat (4) smp(6, 16'h0900);
    idle(2);
    chk("h_pre_vld", 64'(ph_vld), 1);
    smp(3, 16'h0900); smp(3, 16'h0900);
    chk_rd("h_lvl", 8'h0B, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("h_rst_vld",  64'(ph_vld), 0);
    chk("h_rst_data", phw, 0);
    chk("h_rst_fxq",  64'(fx_q), 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    smp(3, 16'h0900); smp(3, 16'h0900);
    idle(3);
    chk("h_idle_after_rst", 64'(ph_vld), 0);
    chk_rd("h_th", 8'h01, 8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
